// File: rtl/panel_pkg.sv
// Shared types and constants for the HUB75 BCM panel driver.
package panel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BLANK   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_UNLATCH = 3'd5,
        ST_SHOW    = 3'd6
    } panel_state_e;

    localparam int unsigned R_BASE  = 11;
    localparam int unsigned G_BASE  = 5;
    localparam int unsigned B_BASE  = 0;
    localparam int unsigned R_WIDTH = 5;
    localparam int unsigned G_WIDTH = 6;
    localparam int unsigned B_WIDTH = 5;

    // Two-bit {lower half, upper half} colour lanes driven onto the connector.
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } panel_rgb_t;

    // {r,g,b} bits of plane p when only the top 'planes' bits of each field are used.
    function automatic logic [2:0] plane_bits(input logic [15:0] px,
                                              input int unsigned planes,
                                              input int unsigned p);
        logic [2:0] bits;
        bits[2] = px[4'(R_BASE + R_WIDTH - planes + p)];
        bits[1] = px[4'(G_BASE + G_WIDTH - planes + p)];
        bits[0] = px[4'(B_BASE + B_WIDTH - planes + p)];
        return bits;
    endfunction

endpackage

// File: rtl/panel_tick_gen.sv
// Enable strobe asserted once every PRESCALER+1 core clocks.
module panel_tick_gen #(
    parameter int unsigned PRESCALER = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick_c
);

    localparam int unsigned CW = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick_c = (cnt_q == CW'(PRESCALER));

    always_comb begin
        cnt_d = o_tick_c ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/panel_bcm_driver.sv
// HUB75 driver with binary-coded-modulation greyscale; the next bit plane is
// shifted into the panel while the previously latched plane is on display.
module panel_bcm_driver
    import panel_pkg::*;
#(
    parameter int unsigned PRESCALER = 0,
    parameter int unsigned COLS      = 64,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned PLANES    = 5,
    parameter int unsigned BASE_ON   = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  o_ram_addr,
    input  logic [15:0]                       i_ram_b1_data,
    input  logic [15:0]                       i_ram_b2_data,
    output logic                              o_ram_read_stb,
    output logic                              o_data_clock,
    output logic                              o_data_latch,
    output logic                              o_data_blank,
    output logic [1:0]                        o_data_r,
    output logic [1:0]                        o_data_g,
    output logic [1:0]                        o_data_b,
    output logic [ROW_BITS-1:0]               o_row_select,
    output logic                              o_frame_done
);

    localparam int unsigned COL_AW = $clog2(COLS);
    localparam int unsigned ADDR_W = ROW_BITS + COL_AW;
    localparam int unsigned CNT_W  = $clog2(COLS) + 1;
    localparam int unsigned TMR_W  = $clog2(BASE_ON << (PLANES - 1)) + 1;
    localparam int unsigned PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;

    logic tick_c;

    panel_tick_gen #(
        .PRESCALER (PRESCALER)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .o_tick_c (tick_c)
    );

    panel_state_e          state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [PL_W-1:0]       plane_q, plane_d;
    logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
    logic                  phase_q, phase_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  stb_q, stb_d;
    logic                  dclk_q, dclk_d;
    logic                  latch_q, latch_d;
    logic                  blank_q, blank_d;
    panel_rgb_t            rgb_q, rgb_d;
    logic [ROW_BITS-1:0]   row_sel_q, row_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic [2:0]            b1_bits_c;
    logic [2:0]            b2_bits_c;
    logic                  timer_expiring_c;
    logic                  last_plane_c;
    logic                  last_row_c;

    assign b1_bits_c        = plane_bits(i_ram_b1_data, PLANES, 32'(plane_q));
    assign b2_bits_c        = plane_bits(i_ram_b2_data, PLANES, 32'(plane_q));
    assign timer_expiring_c = (timer_q <= TMR_W'(1));
    assign last_plane_c     = (plane_q == PL_W'(PLANES - 1));
    assign last_row_c       = (row_q == {ROW_BITS{1'b1}});

    // Next-state and output decode; everything advances on ticks only.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_cnt_d    = col_cnt_q;
        phase_d      = phase_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        stb_d        = stb_q;
        dclk_d       = dclk_q;
        latch_d      = latch_q;
        blank_d      = blank_q;
        rgb_d        = rgb_q;
        row_sel_d    = row_sel_q;
        frame_done_d = 1'b0;

        if (tick_c) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TMR_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    // The last shown plane keeps its full on-time before blanking.
                    if (timer_expiring_c) begin
                        blank_d = 1'b1;
                    end
                    if (i_enable) begin
                        state_d   = ST_SHIFT;
                        stb_d     = 1'b1;
                        addr_d    = {row_q, {COL_AW{1'b0}}};
                        col_cnt_d = CNT_W'(COLS);
                        phase_d   = 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (!phase_q) begin
                        dclk_d  = 1'b1;
                        rgb_d.r = {b2_bits_c[2], b1_bits_c[2]};
                        rgb_d.g = {b2_bits_c[1], b1_bits_c[1]};
                        rgb_d.b = {b2_bits_c[0], b1_bits_c[0]};
                        addr_d  = {addr_q[ADDR_W-1:COL_AW], addr_q[COL_AW-1:0] + COL_AW'(1)};
                        phase_d = 1'b1;
                    end else begin
                        dclk_d    = 1'b0;
                        col_cnt_d = col_cnt_q - CNT_W'(1);
                        phase_d   = 1'b0;
                        if (col_cnt_q == CNT_W'(1)) begin
                            stb_d   = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (timer_expiring_c) begin
                        state_d = ST_BLANK;
                    end
                end

                ST_BLANK: begin
                    blank_d = 1'b1;
                    state_d = ST_LATCH;
                end

                ST_LATCH: begin
                    latch_d = 1'b1;
                    if (plane_q == '0) begin
                        row_sel_d = row_q;
                    end
                    state_d = ST_UNLATCH;
                end

                ST_UNLATCH: begin
                    latch_d = 1'b0;
                    state_d = ST_SHOW;
                end

                ST_SHOW: begin
                    blank_d = 1'b0;
                    timer_d = TMR_W'(BASE_ON) << plane_q;
                    if (last_plane_c) begin
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                        if (last_row_c) begin
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + PL_W'(1);
                    end
                    if (i_enable) begin
                        state_d   = ST_SHIFT;
                        stb_d     = 1'b1;
                        addr_d    = {row_d, {COL_AW{1'b0}}};
                        col_cnt_d = CNT_W'(COLS);
                        phase_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_cnt_q    <= '0;
            phase_q      <= 1'b0;
            timer_q      <= '0;
            addr_q       <= '0;
            stb_q        <= 1'b0;
            dclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            blank_q      <= 1'b1;
            rgb_q        <= '0;
            row_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_cnt_q    <= col_cnt_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            stb_q        <= stb_d;
            dclk_q       <= dclk_d;
            latch_q      <= latch_d;
            blank_q      <= blank_d;
            rgb_q        <= rgb_d;
            row_sel_q    <= row_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_ram_addr     = addr_q;
    assign o_ram_read_stb = stb_q;
    assign o_data_clock   = dclk_q;
    assign o_data_latch   = latch_q;
    assign o_data_blank   = blank_q;
    assign o_data_r       = rgb_q.r;
    assign o_data_g       = rgb_q.g;
    assign o_data_b       = rgb_q.b;
    assign o_row_select   = row_sel_q;
    assign o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_panel_bcm_driver.sv
// Directed bench for panel_bcm_driver: 4 columns, 2 rows, 2 planes, base on-time 8.
module tb_panel_bcm_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [2:0]  ram_addr;
    logic [15:0] b1;
    logic [15:0] b2;
    logic        read_stb;
    logic        dclk;
    logic        latch;
    logic        blank;
    logic [1:0]  dr;
    logic [1:0]  dg;
    logic [1:0]  db;
    logic        row_sel;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    int n_dclk  = 0;
    int n_latch = 0;
    int n_fd    = 0;
    int n_gb    = 0;
    logic dclk_prev  = 1'b0;
    logic latch_prev = 1'b0;

    panel_bcm_driver #(
        .PRESCALER (0),
        .COLS      (4),
        .ROW_BITS  (1),
        .PLANES    (2),
        .BASE_ON   (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .o_ram_addr     (ram_addr),
        .i_ram_b1_data  (b1),
        .i_ram_b2_data  (b2),
        .o_ram_read_stb (read_stb),
        .o_data_clock   (dclk),
        .o_data_latch   (latch),
        .o_data_blank   (blank),
        .o_data_r       (dr),
        .o_data_g       (dg),
        .o_data_b       (db),
        .o_row_select   (row_sel),
        .o_frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (dclk && !dclk_prev) n_dclk = n_dclk + 1;
        if (latch && !latch_prev) n_latch = n_latch + 1;
        if (frame_done) n_fd = n_fd + 1;
        if ((dg != 2'b00) || (db != 2'b00)) n_gb = n_gb + 1;
        dclk_prev  = dclk;
        latch_prev = latch;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] vb1 [4];
    logic [15:0] vb2 [4];
    logic [5:0]  ve0 [4];
    logic [5:0]  ve1 [4];
    int c_dclk;
    int c_latch;
    int c_fd;
    int c_gb;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        b1     = 16'h4000;
        b2     = 16'h8000;
        ticks(2);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_dclk", 32'(dclk), 32'd0);
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_rowsel", 32'(row_sel), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_stb", 32'(read_stb), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_rgb", 32'({dr, dg, db}), 32'd0);

        // Run into SHIFT, then reset asynchronously for three cycles.
        rst_n  = 1'b1;
        enable = 1'b1;
        ticks(4);
        chk("pre_rst_dclk", 32'(dclk), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_dclk", 32'(dclk), 32'd0);
        chk("async_blank", 32'(blank), 32'd1);
        chk("async_addr", 32'(ram_addr), 32'd0);
        ticks(3);
        chk("low_latch", 32'(latch), 32'd0);
        chk("low_rowsel", 32'(row_sel), 32'd0);
        chk("low_addr", 32'(ram_addr), 32'd0);
        chk("low_blank", 32'(blank), 32'd1);
        rst_n   = 1'b1;
        c_dclk  = n_dclk;
        c_latch = n_latch;
        c_fd    = n_fd;
        c_gb    = n_gb;

        ticks(1);   // edge 1: leave IDLE
        chk("e1_dclk", 32'(dclk), 32'd0);
        chk("e1_stb", 32'(read_stb), 32'd1);
        chk("e1_addr", 32'(ram_addr), 32'd0);
        ticks(1);   // edge 2: first data clock, plane 0
        chk("e2_dclk", 32'(dclk), 32'd1);
        chk("p0_r", 32'(dr), 32'd1);
        chk("e2_addr", 32'(ram_addr), 32'd1);
        ticks(7);   // edge 9: last tick B
        chk("e9_stb", 32'(read_stb), 32'd0);
        chk("p0_pulses", 32'(n_dclk - c_dclk), 32'd4);
        ticks(3);   // edge 12: latch plane 0
        chk("e12_latch", 32'(latch), 32'd1);
        chk("e12_blank", 32'(blank), 32'd1);
        chk("e12_rowsel", 32'(row_sel), 32'd0);
        ticks(2);   // edge 14: SHOW
        chk("e14_blank", 32'(blank), 32'd0);
        chk("e14_latch", 32'(latch), 32'd0);
        chk("e14_addr", 32'(ram_addr), 32'd0);
        chk("e14_stb", 32'(read_stb), 32'd1);
        ticks(1);   // edge 15: plane 1 data
        chk("p1_dclk", 32'(dclk), 32'd1);
        chk("p1_r", 32'(dr), 32'd2);
        ticks(8);   // edge 23
        chk("p0_on_9", 32'(blank), 32'd0);
        ticks(1);   // edge 24: blank after 10 ticks
        chk("p0_on_10", 32'(blank), 32'd1);
        ticks(1);   // edge 25
        chk("e25_latch", 32'(latch), 32'd1);
        ticks(2);   // edge 27: SHOW plane 1, next row 1
        chk("e27_blank", 32'(blank), 32'd0);
        chk("e27_addr", 32'(ram_addr), 32'd4);
        ticks(1);   // edge 28
        chk("e28_addr", 32'(ram_addr), 32'd5);
        chk("r1p0_r", 32'(dr), 32'd1);
        ticks(15);  // edge 43
        chk("p1_on_16", 32'(blank), 32'd0);
        ticks(1);   // edge 44: plane 1 blank low 17 ticks
        chk("p1_on_17", 32'(blank), 32'd1);
        ticks(1);   // edge 45
        chk("e45_rowsel", 32'(row_sel), 32'd1);
        ticks(14);  // edge 59
        chk("e59_fd", 32'(frame_done), 32'd0);
        chk("e59_fdcount", 32'(n_fd - c_fd), 32'd0);
        ticks(1);   // edge 60: SHOW of last plane
        chk("e60_fd", 32'(frame_done), 32'd1);
        ticks(1);
        chk("e61_fd", 32'(frame_done), 32'd0);
        ticks(17);  // edge 78: row 0 again
        chk("e78_latch", 32'(latch), 32'd1);
        chk("e78_rowsel", 32'(row_sel), 32'd0);
        chk("frame_latches", 32'(n_latch - c_latch), 32'd4);
        chk("frame_fd", 32'(n_fd - c_fd), 32'd1);
        chk("no_gb", 32'(n_gb - c_gb), 32'd0);

        // Colour bit selection: {r,g,b} lanes expected in plane 0 and plane 1.
        vb1[0] = 16'h0400; vb2[0] = 16'h0000; ve0[0] = 6'b000000; ve1[0] = 6'b000100;
        vb1[1] = 16'h0200; vb2[1] = 16'h0000; ve0[1] = 6'b000100; ve1[1] = 6'b000000;
        vb1[2] = 16'h0100; vb2[2] = 16'h0000; ve0[2] = 6'b000000; ve1[2] = 6'b000000;
        vb1[3] = 16'h0008; vb2[3] = 16'h0010; ve0[3] = 6'b000001; ve1[3] = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            rst_n = 1'b0;
            ticks(1);
            b1    = vb1[i];
            b2    = vb2[i];
            rst_n = 1'b1;
            ticks(2);
            chk($sformatf("sel%0d_p0", i), 32'({dr, dg, db}), 32'(ve0[i]));
            ticks(13);
            chk($sformatf("sel%0d_p1", i), 32'({dr, dg, db}), 32'(ve1[i]));
        end

        // Enable dropped mid-shift: plane completes, is shown, then idles.
        rst_n  = 1'b0;
        ticks(1);
        b1     = 16'h4000;
        b2     = 16'h8000;
        rst_n  = 1'b1;
        enable = 1'b1;
        ticks(5);
        enable = 1'b0;
        ticks(7);   // edge 12
        chk("dis_latch", 32'(latch), 32'd1);
        ticks(2);   // edge 14
        chk("dis_show_blank", 32'(blank), 32'd0);
        c_dclk = n_dclk;
        ticks(7);   // edge 21
        chk("dis_on_7", 32'(blank), 32'd0);
        ticks(1);   // edge 22
        chk("dis_on_8", 32'(blank), 32'd1);
        ticks(20);
        chk("dis_no_dclk", 32'(n_dclk - c_dclk), 32'd0);
        chk("dis_blank", 32'(blank), 32'd1);
        chk("dis_stb", 32'(read_stb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
